bandai_mapper_gen2: RTL and testbench

- Parametrised successor cartridge mapper for the handheld bus.
- Gates cartridge access behind a two-address unlock sequence with timeout, then serially emits a configurable console-control bitstream on SO.
- Holds linear-offset and bank registers wider than 8 bits through extended ports; decodes ROM/RAM chip-enables and drives the high memory address lines.
- Sits between console cartridge bus (ADDR = A-1..A3 + A15..A18) and external ROM/RAM.

---
 rtl/mapper_pkg.sv | 27 ++
 rtl/mapper_unlock_seq.sv | 74 +++++++
 rtl/bandai_mapper_gen2.sv | 210 +++++++++++++++++++++
 tb/tb_bandai_mapper_gen2.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mapper_pkg.sv
// Shared constants for the gen2 cartridge mapper: I/O port numbers,
// unlock FSM states and the default key/bitstream values.
package mapper_pkg;

  localparam logic [7:0] PORT_C0 = 8'hC0;
  localparam logic [7:0] PORT_C1 = 8'hC1;
  localparam logic [7:0] PORT_C2 = 8'hC2;
  localparam logic [7:0] PORT_C3 = 8'hC3;
  localparam logic [7:0] PORT_D0 = 8'hD0;
  localparam logic [7:0] PORT_D1 = 8'hD1;
  localparam logic [7:0] PORT_D2 = 8'hD2;
  localparam logic [7:0] PORT_D3 = 8'hD3;
  localparam logic [7:0] PORT_CE = 8'hCE;

  typedef enum logic [1:0] {
    WAIT_ACK = 2'd0,
    WAIT_NAK = 2'd1,
    UNLOCKED = 2'd2
  } unlock_state_e;

  localparam logic [7:0]  DEF_KEY_ACK    = 8'h5A;
  localparam logic [7:0]  DEF_KEY_NAK    = 8'hA5;
  localparam int          DEF_BITS_LEN   = 18;
  localparam logic [17:0] DEF_BITS_VAL   = {1'b0, 16'h28A0, 1'b0};
  localparam int          DEF_UNLOCK_TMO = 64;

endpackage

// File: rtl/mapper_unlock_seq.sv
// Two-address unlock sequencer with timeout; on unlock it streams the
// console-control bitstream LSB first on so_o, idling high otherwise.
module mapper_unlock_seq
  import mapper_pkg::*;
#(
  parameter int                  BITS_LEN   = DEF_BITS_LEN,
  parameter logic [BITS_LEN-1:0] BITS_VAL   = DEF_BITS_VAL,
  parameter logic [7:0]          KEY_ACK    = DEF_KEY_ACK,
  parameter logic [7:0]          KEY_NAK    = DEF_KEY_NAK,
  parameter int                  UNLOCK_TMO = DEF_UNLOCK_TMO
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [7:0] addr_i,
  output logic       unlocked_o,
  output logic       so_o
);

  localparam int CNT_W = (UNLOCK_TMO > 2) ? $clog2(UNLOCK_TMO) : 1;
  localparam logic [BITS_LEN-1:0] MSB_ONE = BITS_LEN'(1) << (BITS_LEN - 1);

  unlock_state_e       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BITS_LEN-1:0] sr_q, sr_d;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= WAIT_ACK;
      cnt_q   <= '0;
      sr_q    <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // Default is a shift with 1 fill; key-match cycles override it.
    sr_d    = (sr_q >> 1) | MSB_ONE;
    case (state_q)
      WAIT_ACK: begin
        if (addr_i == KEY_ACK) begin
          state_d = WAIT_NAK;
          cnt_d   = '0;
          sr_d    = sr_q;
        end
      end
      WAIT_NAK: begin
        if (addr_i == KEY_NAK) begin
          state_d = UNLOCKED;
          sr_d    = BITS_VAL;
        end else if (cnt_q == CNT_W'(UNLOCK_TMO - 1)) begin
          state_d = WAIT_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UNLOCKED: begin
      end
      default: begin
        state_d = WAIT_ACK;
        cnt_d   = '0;
      end
    endcase
  end

  assign unlocked_o = (state_q == UNLOCKED);
  assign so_o       = sr_q[0];

endmodule

// File: rtl/bandai_mapper_gen2.sv
// Gen2 cartridge mapper top: unlock gate, offset/bank register file, chip-enable
// decode and high address mux. Define MAPPER_BYTEMODE_EN to add the BYTEn port (CE).
module bandai_mapper_gen2
  import mapper_pkg::*;
#(
  parameter int                  RADDR_W    = 7,
  parameter int                  BITS_LEN   = DEF_BITS_LEN,
  parameter logic [BITS_LEN-1:0] BITS_VAL   = DEF_BITS_VAL,
  parameter logic [7:0]          KEY_ACK    = DEF_KEY_ACK,
  parameter logic [7:0]          KEY_NAK    = DEF_KEY_NAK,
  parameter int                  UNLOCK_TMO = DEF_UNLOCK_TMO
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               CEn,
  input  logic               SSn,
  input  logic               WEn,
  input  logic               OEn,
  input  logic [7:0]         ADDR,
  input  logic [7:0]         DQ_I,
  output logic [7:0]         DQ_O,
  output logic               DQ_OE,
  output logic               SO,
  output logic               ROMCEn,
  output logic               RAMCEn,
  output logic [RADDR_W-1:0] RADDR
);

  localparam int LAO_W   = RADDR_W - 4;
  localparam int BANK_W  = RADDR_W;
  localparam bit LAO_HI  = (LAO_W > 8);
  localparam bit BANK_HI = (BANK_W > 8);
`ifdef MAPPER_BYTEMODE_EN
  localparam bit BYTEMODE = 1'b1;
`else
  localparam bit BYTEMODE = 1'b0;
`endif

  logic unlocked;

  mapper_unlock_seq #(
    .BITS_LEN  (BITS_LEN),
    .BITS_VAL  (BITS_VAL),
    .KEY_ACK   (KEY_ACK),
    .KEY_NAK   (KEY_NAK),
    .UNLOCK_TMO(UNLOCK_TMO)
  ) u_unlock (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .addr_i    (ADDR),
    .unlocked_o(unlocked),
    .so_o      (SO)
  );

  function automatic logic port_impl(input logic [7:0] port);
    case (port)
      PORT_C0, PORT_C1, PORT_C2, PORT_C3: port_impl = 1'b1;
      PORT_D0:                            port_impl = LAO_HI;
      PORT_D1, PORT_D2, PORT_D3:          port_impl = BANK_HI;
      PORT_CE:                            port_impl = BYTEMODE;
      default:                            port_impl = 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] merge_byte(input logic [15:0] cur, input logic hi,
                                             input logic [7:0] d);
    merge_byte = hi ? {d, cur[7:0]} : {cur[15:8], d};
  endfunction

  logic iosel;
  assign iosel = ~SSn | ~CEn;

  // Write capture: the strobe's rising edge commits whatever was seen while low.
  logic       wen_q;
  logic       wr_iosel_q;
  logic [7:0] wr_port_q;
  logic [7:0] wr_data_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wen_q      <= 1'b1;
      wr_iosel_q <= 1'b0;
      wr_port_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wen_q <= WEn;
      if (!WEn) begin
        wr_iosel_q <= iosel;
        wr_port_q  <= ADDR;
        wr_data_q  <= DQ_I;
      end
    end
  end

  logic commit;
  logic wr_hi;
  assign commit = ~wen_q & WEn & unlocked & wr_iosel_q & port_impl(wr_port_q);
  assign wr_hi  = (wr_port_q[7:4] == 4'hD);

  logic [LAO_W-1:0] lao_q, lao_d;
  logic [15:0]      lao_x;
  assign lao_x = 16'(lao_q);

  always_comb begin
    lao_d = lao_q;
    if (commit && wr_port_q[3:0] == 4'h0)
      lao_d = LAO_W'(merge_byte(lao_x, wr_hi, wr_data_q));
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) lao_q <= '1;
    else       lao_q <= lao_d;
  end

  // Index 0 = RAMB (C1/D1), 1 = ROMB0 (C2/D2), 2 = ROMB1 (C3/D3).
  logic [2:0][BANK_W-1:0] bank_vec;
  logic [2:0][15:0]       bank_x;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_bank
      logic [BANK_W-1:0] bank_q, bank_d;

      always_comb begin
        bank_d = bank_q;
        if (commit && wr_port_q[3:0] == 4'(gi + 1))
          bank_d = BANK_W'(merge_byte(16'(bank_q), wr_hi, wr_data_q));
      end

      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) bank_q <= '1;
        else       bank_q <= bank_d;
      end

      assign bank_vec[gi] = bank_q;
      assign bank_x[gi]   = 16'(bank_q);
    end
  endgenerate

`ifdef MAPPER_BYTEMODE_EN
  logic byten_q, byten_d;

  always_comb begin
    byten_d = byten_q;
    if (commit && wr_port_q == PORT_CE) byten_d = ~wr_data_q[0];
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) byten_q <= 1'b1;
    else       byten_q <= byten_d;
  end
`endif

  logic [7:0] rd_byte;

  always_comb begin
    rd_byte = 8'h00;
    case (ADDR)
      PORT_C0: rd_byte = lao_x[7:0];
      PORT_D0: rd_byte = lao_x[15:8];
      PORT_C1: rd_byte = bank_x[0][7:0];
      PORT_D1: rd_byte = bank_x[0][15:8];
      PORT_C2: rd_byte = bank_x[1][7:0];
      PORT_D2: rd_byte = bank_x[1][15:8];
      PORT_C3: rd_byte = bank_x[2][7:0];
      PORT_D3: rd_byte = bank_x[2][15:8];
`ifdef MAPPER_BYTEMODE_EN
      PORT_CE: rd_byte = {7'b0, byten_q};
`endif
      default: rd_byte = 8'h00;
    endcase
  end

  assign DQ_OE = unlocked & iosel & ~OEn & WEn & port_impl(ADDR);
  assign DQ_O  = DQ_OE ? rd_byte : 8'h00;

  logic [3:0] win;
  logic       rce;
  logic       ram_win;
  logic       rom_win;
  logic       ram_as_rom;

  assign win     = ADDR[7:4];
  assign rce     = unlocked & SSn & ~CEn;
  assign ram_win = (win == 4'd1);
  assign rom_win = (win >= 4'd2);
`ifdef MAPPER_BYTEMODE_EN
  // Byte mode maps the RAM window onto ROM while keeping the RAMB bank.
  assign ram_as_rom = ram_win & ~byten_q;
`else
  assign ram_as_rom = 1'b0;
`endif

  assign RAMCEn = ~(rce & ram_win & ~ram_as_rom);
  assign ROMCEn = ~(rce & (rom_win | ram_as_rom));

  always_comb begin
    RADDR = '0;
    if (rce) begin
      case (win)
        4'd0:    RADDR = '0;
        4'd1:    RADDR = bank_vec[0];
        4'd2:    RADDR = bank_vec[1];
        4'd3:    RADDR = bank_vec[2];
        default: RADDR = {lao_q, win};
      endcase
    end
  end

endmodule

// File: tb/tb_bandai_mapper_gen2.sv
// Directed bench for bandai_mapper_gen2: two instances (RADDR_W=7 and 10)
// share one bus; expected values are hand-derived constants.
module tb_bandai_mapper_gen2;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       CEn, SSn, WEn, OEn;
  logic [7:0] ADDR, DQ_I;

  logic [7:0] dq_o7, dq_o10;
  logic       dq_oe7, dq_oe10, so7, so10;
  logic       romcen7, ramcen7, romcen10, ramcen10;
  logic [6:0] raddr7;
  logic [9:0] raddr10;

  int checks = 0;
  int errors = 0;

  // Default bitstream, emitted LSB first after the unlock.
  logic [17:0] exp_bits = {1'b0, 16'h28A0, 1'b0};

  always #5 CLK = ~CLK;

  bandai_mapper_gen2 #(.RADDR_W(7)) u_dut7 (
    .CLK(CLK), .RSTn(RSTn), .CEn(CEn), .SSn(SSn), .WEn(WEn), .OEn(OEn),
    .ADDR(ADDR), .DQ_I(DQ_I), .DQ_O(dq_o7), .DQ_OE(dq_oe7), .SO(so7),
    .ROMCEn(romcen7), .RAMCEn(ramcen7), .RADDR(raddr7)
  );

  bandai_mapper_gen2 #(.RADDR_W(10)) u_dut10 (
    .CLK(CLK), .RSTn(RSTn), .CEn(CEn), .SSn(SSn), .WEn(WEn), .OEn(OEn),
    .ADDR(ADDR), .DQ_I(DQ_I), .DQ_O(dq_o10), .DQ_OE(dq_oe10), .SO(so10),
    .ROMCEn(romcen10), .RAMCEn(ramcen10), .RADDR(raddr10)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    CEn = 1'b1; SSn = 1'b1; WEn = 1'b1; OEn = 1'b1; ADDR = 8'h00;
  endtask

  task automatic wr(input logic [7:0] port, input logic [7:0] data);
    CEn = 1'b1; SSn = 1'b0; OEn = 1'b1; WEn = 1'b0; ADDR = port; DQ_I = data;
    tick();
    WEn = 1'b1; SSn = 1'b1; ADDR = 8'h00;
    tick();
  endtask

  task automatic rd(input logic [7:0] port);
    @(negedge CLK);
    CEn = 1'b1; SSn = 1'b0; WEn = 1'b1; OEn = 1'b0; ADDR = port;
    #1;
  endtask

  task automatic acc(input logic [7:0] a);
    @(negedge CLK);
    CEn = 1'b0; SSn = 1'b1; WEn = 1'b1; OEn = 1'b1; ADDR = a;
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RSTn = 1'b0; DQ_I = 8'h00;
    idle();
    repeat (2) tick();
    RSTn = 1'b1;
    tick();

    // Reset state
    chk("rst_so", so7, 1'b1);
    acc(8'h20);
    chk("rst_romcen", romcen7, 1'b1);
    chk("rst_ramcen", ramcen7, 1'b1);
    chk("rst_raddr", raddr7, 7'h00);
    rd(8'hC0);
    chk("rst_dq_oe", dq_oe7, 1'b0);
    chk("rst_dq_o", dq_o7, 8'h00);
    idle();

    // Write while locked must be dropped
    wr(8'hC1, 8'h00);

    // ACK, 64 idle cycles (timeout), then NAK: stays locked
    ADDR = 8'h5A; tick();
    ADDR = 8'h00; repeat (64) tick();
    ADDR = 8'hA5; tick();
    acc(8'h20);
    chk("tmo_romcen", romcen7, 1'b1);
    chk("tmo_so", so7, 1'b1);
    idle();
    tick();

    // ACK then NAK on the next cycle: unlock and bitstream
    ADDR = 8'h5A; tick();
    ADDR = 8'hA5; tick();
    ADDR = 8'h00;
    chk("so_bit0", so7, exp_bits[0]);
    for (int k = 1; k < 18; k++) begin
      tick();
      chk($sformatf("so_bit%0d", k), so7, exp_bits[k]);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("so_idle7", so7, 1'b1);
      chk("so_idle10", so10, 1'b1);
    end

    // Locked write ignored: RAMB still at reset (all ones, zero-extended)
    rd(8'hC1);
    chk("c1_oe", dq_oe7, 1'b1);
    chk("c1_rd7", dq_o7, 8'h7F);
    chk("c1_rd10", dq_o10, 8'hFF);
    idle();

    // ROMB0 and LAO windows
    wr(8'hC2, 8'h15);
    acc(8'h20);
    chk("rom0_ce", romcen7, 1'b0);
    chk("rom0_ramce", ramcen7, 1'b1);
    chk("rom0_ra7", raddr7, 7'h15);
    chk("rom0_ra10", raddr10, 10'h315);
    acc(8'h50);
    chk("lao_ra7", raddr7, 7'h75);
    chk("lao_ra10", raddr10, 10'h3F5);
    idle();

    wr(8'hC0, 8'h12);
    wr(8'hC1, 8'h44);
    wr(8'hC3, 8'hAB);
    wr(8'hD3, 8'h03);

    rd(8'hD3);
    chk("d3_oe10", dq_oe10, 1'b1);
    chk("d3_rd10", dq_o10, 8'h03);
    chk("d3_oe7", dq_oe7, 1'b0);
    chk("d3_rd7", dq_o7, 8'h00);
    rd(8'hC3);
    chk("c3_rd10", dq_o10, 8'hAB);
    chk("c3_rd7", dq_o7, 8'h2B);
    rd(8'hC0);
    chk("c0_rd7", dq_o7, 8'h02);
    chk("c0_rd10", dq_o10, 8'h12);
    rd(8'hC8);
    chk("c8_oe7", dq_oe7, 1'b0);
    chk("c8_oe10", dq_oe10, 1'b0);
    rd(8'hD0);
    chk("d0_oe10", dq_oe10, 1'b0);
    @(negedge CLK);
    OEn = 1'b1; #1;
    chk("oen_hi_oe", dq_oe10, 1'b0);
    idle();

    acc(8'h30);
    chk("rom1_ra7", raddr7, 7'h2B);
    chk("rom1_ra10", raddr10, 10'h3AB);
    acc(8'h90);
    chk("lao2_ra7", raddr7, 7'h29);
    chk("lao2_ra10", raddr10, 10'h129);
    acc(8'h10);
    chk("ram_ce", ramcen7, 1'b0);
    chk("ram_romce", romcen7, 1'b1);
    chk("ram_ra7", raddr7, 7'h44);
    chk("ram_ra10", raddr10, 10'h344);
    acc(8'h05);
    chk("win0_romce", romcen7, 1'b1);
    chk("win0_ramce", ramcen7, 1'b1);
    chk("win0_ra", raddr7, 7'h00);
    @(negedge CLK);
    CEn = 1'b0; SSn = 1'b0; ADDR = 8'h20; #1;
    chk("iosel_romce", romcen7, 1'b1);
    idle();

`ifdef MAPPER_BYTEMODE_EN
    wr(8'hCE, 8'h01);
    acc(8'h10);
    chk("byte_romce", romcen7, 1'b0);
    chk("byte_ramce", ramcen7, 1'b1);
    chk("byte_ra7", raddr7, 7'h44);
    rd(8'hCE);
    chk("byte_rd", dq_o7, 8'h00);
    idle();
`else
    rd(8'hCE);
    chk("ce_unimpl_oe", dq_oe7, 1'b0);
    idle();
`endif

    // Asynchronous reset mid-use
    acc(8'h20);
    chk("pre_rst_romce", romcen7, 1'b0);
    RSTn = 1'b0;
    #1;
    chk("arst_romce", romcen7, 1'b1);
    chk("arst_ra", raddr7, 7'h00);
    chk("arst_so", so7, 1'b1);
    idle();
    tick(); tick();
    RSTn = 1'b1;
    tick();

    // NAK exactly on the last allowed cycle still unlocks
    ADDR = 8'h5A; tick();
    ADDR = 8'h00; repeat (63) tick();
    ADDR = 8'hA5; tick();
    ADDR = 8'h00;
    acc(8'h20);
    chk("edge_romce", romcen7, 1'b0);
    chk("edge_ra7", raddr7, 7'h7F);
    chk("edge_ra10", raddr10, 10'h3FF);
    rd(8'hC2);
    chk("edge_c2_rd7", dq_o7, 8'h7F);
`ifdef MAPPER_BYTEMODE_EN
    rd(8'hCE);
    chk("byte_rst_rd", dq_o7, 8'h01);
`endif
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
